r3_small_decode: RTL

- Receiving end of the small-polynomial path. The mod-3 reduction datapath produces trits and the encoder packs them; this block unpacks the byte stream back into signed trits.
- Accepts packed bytes holding 4 coefficients each (2-bit fields, value+1, LSB field first). Emits one signed trit per cycle with valid/ready handshakes on both sides.
- Sits between the byte-wide key/ciphertext input buffer and the polynomial coefficient RAM writer.

---
 rtl/r3_small_decode_pkg.sv | 42 ++++
 rtl/r3_small_decode_field_map.sv | 13 +
 rtl/r3_small_decode.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/r3_small_decode_pkg.sv
// Shared definitions for the small-polynomial trit unpacker: trit encodings,
// FSM states and field helpers.
package r3_small_decode_pkg;

  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;

  localparam int unsigned P_DEFAULT = 757;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  // Packed field holds value+1; field 3 has no meaning and decodes as zero.
  function automatic logic [1:0] field_to_trit(input logic [1:0] field);
    logic [1:0] t;
    case (field)
      2'd0:    t = TRIT_NEG;
      2'd1:    t = TRIT_ZERO;
      2'd2:    t = TRIT_POS;
      default: t = TRIT_ZERO;
    endcase
    return t;
  endfunction

  // One bit per field of a byte that carries a real coefficient.
  function automatic logic [3:0] field_mask(input logic [2:0] nfield);
    logic [3:0] m;
    case (nfield)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/r3_small_decode_field_map.sv
// Combinational decode of one 2-bit packed field into a signed trit.
module r3_field_map
  import r3_small_decode_pkg::*;
(
  input  logic [1:0] field,
  output logic [1:0] trit,
  output logic       invalid
);

  assign trit    = field_to_trit(field);
  assign invalid = (field == 2'b11);

endmodule

// File: rtl/r3_small_decode.sv
// Unpacks bytes of four 2-bit fields into a stream of signed trits with
// valid/ready on both sides, one trit per cycle sustained.
module r3_small_decode
  import r3_small_decode_pkg::*;
#(
  parameter int unsigned P  = P_DEFAULT,
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [1:0]    trit,
  output logic [CW-1:0] trit_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          err
);

  localparam logic [CW:0]   P_EXT    = (CW+1)'(P);
  localparam logic [CW-1:0] LAST_IDX = CW'(P - 1);

  state_t        state;
  state_t        state_next;
  logic [7:0]    tsreg;
  logic [2:0]    nfield;
  logic [CW-1:0] idx;
  logic          err_q;
  logic          busy_q;

  logic [7:0]    lane_trit;
  logic [3:0]    lane_bad;

  logic          consume;
  logic          last_field;
  logic          final_trit;
  logic          in_ready_c;
  logic          load;
  logic [CW-1:0] base;
  logic [CW:0]   remaining;
  logic [2:0]    load_n;
  logic [3:0]    load_mask;
  logic          load_bad;

  // The byte is mapped to trits on entry, so the shift register holds
  // ready-to-emit trits and idles at zero.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    r3_field_map u_map (
      .field  (in_byte[2*g +: 2]),
      .trit   (lane_trit[2*g +: 2]),
      .invalid(lane_bad[g])
    );
  end

  always_comb begin
    state_next = state;
    last_field = (nfield == 3'd1);
    final_trit = (idx == LAST_IDX);
    consume    = (state == EMIT) && out_ready;
    in_ready_c = (state == LOAD) || (consume && last_field && !final_trit);
    load       = in_ready_c && in_valid;

    // Overlapped load belongs to the coefficient after the one being consumed.
    base       = (state == EMIT) ? idx + CW'(1) : idx;
    remaining  = P_EXT - {1'b0, base};
    load_n     = (remaining < (CW+1)'(4)) ? remaining[2:0] : 3'd4;
    load_mask  = field_mask(load_n);

    load_bad   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (load_mask[i]) begin
        load_bad = load_bad | lane_bad[i];
      end else begin
        load_bad = load_bad | (|in_byte[2*i +: 2]);
      end
    end

    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: if (in_valid) state_next = EMIT;
      EMIT: begin
        if (consume && last_field) begin
          if (final_trit)    state_next = IDLE;
          else if (in_valid) state_next = EMIT;
          else               state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsreg  <= '0;
      nfield <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        idx    <= '0;
        err_q  <= 1'b0;
        busy_q <= 1'b1;
      end

      if (load) begin
        tsreg  <= lane_trit;
        nfield <= load_n;
        err_q  <= err_q | load_bad;
      end else if (consume) begin
        if (last_field && final_trit) begin
          tsreg  <= '0;
          nfield <= '0;
        end else begin
          tsreg  <= {2'b00, tsreg[7:2]};
          nfield <= nfield - 3'd1;
        end
      end

      if (consume) begin
        if (last_field && final_trit) begin
          idx    <= '0;
          busy_q <= 1'b0;
        end else begin
          idx <= idx + CW'(1);
        end
      end
    end
  end

  assign in_ready  = in_ready_c;
  assign trit      = tsreg[1:0];
  assign trit_idx  = idx;
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && final_trit;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
